sync_pattern_tx: RTL

Serial frame transmitter that drives the single-bit `w` line consumed by the team's 1011 sequence detector. Each accepted request emits one frame on `w`:

- a fixed 4-bit sync pattern 1011,
- a PAYLOAD_W-bit payload, MSB first,
- one guard bit of 0.

The block sits upstream of the detector on the same clock domain and exposes a start/busy/done handshake to its controller.

---
 rtl/sync_pattern_pkg.sv | 21 ++
 rtl/sync_pattern_tx.sv | 104 ++++++++++
 2 files changed

// File: rtl/sync_pattern_pkg.sv
// Shared constants for the sync-pattern transmitter and the 1011 detector.
// Holds the sync word, its length and the transmitter state encoding.
package sync_pattern_pkg;

   localparam int SYNC_LEN = 4;
   localparam int IDX_W    = $clog2(SYNC_LEN);

   localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SYNC    = 2'b01,
      PAYLOAD = 2'b10,
      GUARD   = 2'b11
   } state_t;

   function automatic int cnt_width(input int pw);
      return (pw > 1) ? $clog2(pw) : 1;
   endfunction

endpackage

// File: rtl/sync_pattern_tx.sv
// Frame transmitter: sync 1011, payload MSB first, then one guard 0.
// All outputs are registered; they reflect the state entered at each edge.
module sync_pattern_tx
   import sync_pattern_pkg::*;
#(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PAYLOAD_W-1:0] data,
   output logic                 w,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = cnt_width(PAYLOAD_W);
   localparam logic [CW-1:0]    CNT_LAST = CW'(PAYLOAD_W - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYNC_LEN - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PAYLOAD_W-1:0] sh_q, sh_d;
   logic                 w_q, w_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         w_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Outputs are computed for the state being entered, so w leads state by 0 cycles.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      w_d     = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SYNC;
               idx_d   = IDX_LAST;
               sh_d    = data;
               w_d     = SYNC_PATTERN[IDX_LAST];
               busy_d  = 1'b1;
            end
         end
         SYNC: begin
            busy_d = 1'b1;
            if (idx_q == '0) begin
               state_d = PAYLOAD;
               cnt_d   = CNT_LAST;
               w_d     = sh_q[PAYLOAD_W-1];
               sh_d    = sh_q << 1;
            end else begin
               idx_d = idx_q - IDX_W'(1);
               w_d   = SYNC_PATTERN[idx_q - IDX_W'(1)];
            end
         end
         PAYLOAD: begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = GUARD;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
               w_d   = sh_q[PAYLOAD_W-1];
               sh_d  = sh_q << 1;
            end
         end
         GUARD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign w    = w_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
